// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// InstrSequencer shared package
//
// Purpose : common types and constants for the instruction sequencer slice.
//           Holds the FSM state enumeration, the memory opcode constants and
//           the halt instruction encoding.
// Contents: seqState_t, OP_STORE, OP_LOAD, HALT_INSTR
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } seqState_t;

    localparam logic [2:0] OP_STORE   = 3'b110;
    localparam logic [2:0] OP_LOAD    = 3'b111;
    localparam logic [8:0] HALT_INSTR = 9'h1FF;

endpackage

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// InstrSequencer bus interface
//
// Purpose : groups every non-clock/reset signal of the sequencer.
// Signals : start_i         one-cycle start pulse
//           instruction_i   9-bit ROM data at address pc_o
//           branchTaken_i   branch decision (used in EXEC)
//           branchTarget_i  branch next-PC (used in EXEC)
//           memAck_i        data memory completion
//           pc_o            instruction fetch address
//           ir_o            latched instruction
//           memReq_o        data memory request
//           memWe_o         data memory write qualifier
//           regWrEn_o       register file write strobe
//           busy_o          executing (FETCH/EXEC/MEM/WB)
//           done_o          halted
//           err_o           memory handshake timeout flag
// Modports: master (environment side), slave (sequencer side)
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int PC_W = 10
);

    logic            start_i;
    logic [8:0]      instruction_i;
    logic            branchTaken_i;
    logic [PC_W-1:0] branchTarget_i;
    logic            memAck_i;
    logic [PC_W-1:0] pc_o;
    logic [8:0]      ir_o;
    logic            memReq_o;
    logic            memWe_o;
    logic            regWrEn_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    modport master (
        output start_i, instruction_i, branchTaken_i, branchTarget_i, memAck_i,
        input  pc_o, ir_o, memReq_o, memWe_o, regWrEn_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, instruction_i, branchTaken_i, branchTarget_i, memAck_i,
        output pc_o, ir_o, memReq_o, memWe_o, regWrEn_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// SeqWatchdog - data memory handshake timeout counter
//
// Purpose : counts MEM cycles spent waiting for an acknowledge and flags the
//           cycle in which the count reaches LIMIT. Only present when the
//           MEM_TIMEOUT_EN macro is defined; otherwise this file is empty.
// Ports   : clk        clock
//           rst_n      asynchronous active-low reset
//           clear_i    restart the count (asserted before entering MEM)
//           count_i    a MEM cycle without acknowledge
//           expired_o  this cycle's increment reaches LIMIT
// ---------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
module seq_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry is flagged combinationally so the sequencer leaves MEM at the
    // end of the cycle whose increment would reach LIMIT.
    assign expired_o = count_i && (count_q == CNT_W'(LIMIT - 1));

    // Clear wins over counting; the two are never requested together.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// InstrSequencer - multi-cycle instruction sequencer
//
// Purpose : steps each instruction through FETCH, EXEC and then MEM and/or
//           WB, driving Moore strobes for data memory and register file.
//           Instruction 9'h1FF halts; opcode 110 is a store, 111 a load,
//           everything else an ALU op.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    instr_sequencer_if.slave (start, instruction, branch,
//                  memory handshake, PC/IR and status outputs)
// Options : MEM_TIMEOUT_EN - when defined, a seq_watchdog aborts a MEM wait
//           after MEM_TO cycles, sets err_o and halts. When undefined, MEM
//           waits indefinitely and err_o is tied low.
// ---------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int MEM_TO = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_sequencer_if.slave bus
);

    seqState_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pcNext_q, pcNext_d;
    logic [8:0]      ir_q, ir_d;
    logic            isStore;
    logic            isMemOp;
    logic            startAccept;
    logic            memTimeout;

    assign isStore     = (ir_q[8:6] == OP_STORE);
    assign isMemOp     = isStore || (ir_q[8:6] == OP_LOAD);
    assign startAccept = bus.start_i && ((state_q == IDLE) || (state_q == HALT));

`ifdef MEM_TIMEOUT_EN
    logic wdClear;
    logic wdCount;
    logic err_q;

    // MEM is only ever entered from EXEC, so clearing there restarts the
    // count for every new memory access.
    assign wdClear = (state_q == EXEC);
    assign wdCount = (state_q == MEM) && !bus.memAck_i;

    seq_watchdog #(
        .LIMIT(MEM_TO)
    ) uWatchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (wdClear),
        .count_i  (wdCount),
        .expired_o(memTimeout)
    );

    // Error flag is sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (startAccept) begin
            err_q <= 1'b0;
        end else if (memTimeout) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign memTimeout = 1'b0;
    assign bus.err_o  = 1'b0;
`endif

    // Next-state logic. The pending next-PC is captured in EXEC and only
    // committed to the PC when the instruction retires (store ack or WB),
    // so the PC keeps pointing at the executing instruction meanwhile.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pcNext_d = pcNext_q;
        ir_d     = ir_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (startAccept) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = bus.instruction_i;
                state_d = EXEC;
            end
            EXEC: begin
                pcNext_d = bus.branchTaken_i ? bus.branchTarget_i : pc_q + 1'b1;
                if (ir_q == HALT_INSTR) begin
                    state_d = HALT;
                end else if (isMemOp) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (bus.memAck_i) begin
                    if (isStore) begin
                        pc_d    = pcNext_q;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (memTimeout) begin
                    state_d = HALT;
                end
            end
            WB: begin
                pc_d    = pcNext_q;
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            pcNext_q <= '0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pcNext_q <= pcNext_d;
            ir_q     <= ir_d;
        end
    end

    // Moore outputs decoded from the registered state only.
    assign bus.pc_o      = pc_q;
    assign bus.ir_o      = ir_q;
    assign bus.memReq_o  = (state_q == MEM);
    assign bus.memWe_o   = (state_q == MEM) && isStore;
    assign bus.regWrEn_o = (state_q == WB);
    assign bus.busy_o    = (state_q == FETCH) || (state_q == EXEC) ||
                           (state_q == MEM)   || (state_q == WB);
    assign bus.done_o    = (state_q == HALT);

endmodule
